fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch stage with a small prefetch FIFO, sitting between instruction memory and decode.
//  - Owns the fetch PC and drives instruction-memory reads.
//  - Queues {instr, pc+2} pairs and presents the head entry to decode in place of the IF/ID register.
//  - Absorbs decode stalls without losing fetch bandwidth.
//  - Flushes and redirects on an EX-stage branch or jump taken.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >= 2
//  PTR_W   2   log2(DEPTH)
//  WIDTH   16  instruction / address width
// PORTS
//  clk           in   1      system clock; all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  redirect      in   1      EX branch/jump taken: flush queue, load redirect_pc
//  redirect_pc   in   WIDTH  target PC; used only when redirect=1
//  stall         in   1      decode hazard stall: head entry not consumed this cycle
//  imem_addr     out  WIDTH  instruction-memory address (= fetch_pc); read data returns same cycle
//  imem_data     in   WIDTH  instruction word at imem_addr
//  id_instr      out  WIDTH  head instruction; 16'h0800 (NOP) when id_valid=0
//  id_pc_inc     out  WIDTH  head entry's PC+2; 0 when id_valid=0
//  id_valid      out  1      queue non-empty and no redirect this cycle
//  count         out  PTR_W+1  occupancy, 0..DEPTH
//  halted        out  1      HALT (opcode 5'b00000) enqueued; fetching stopped
// BEHAVIOUR
//  Reset (rst=1 at edge)
//   - fetch_pc=0, head=tail=0, count=0, halted=0.
//   - Outputs: id_valid=0, id_instr=16'h0800, id_pc_inc=0, imem_addr=0.
//   - rst overrides redirect, push and pop in the same cycle.
//  Pop
//   - pop = id_valid & ~stall.
//   - head advances mod DEPTH; count decrements.
//  Push
//   - push = ~redirect & ~halted & (count<DEPTH | pop).
//   - Writes {imem_data, fetch_pc+2} at tail; tail advances mod DEPTH; fetch_pc <= fetch_pc+2.
//   - 16-bit wrap of fetch_pc+2 is silent (FFFE -> 0000).
//  Simultaneous push and pop
//   - count unchanged; legal when full and when count=1.
//   - When empty there is no bypass: a pushed entry is visible on the id_* outputs the next cycle.
//   - This gives 1-cycle fetch-to-decode latency, identical to a plain IF/ID register.
//  Full
//   - count=DEPTH and no pop: no push, fetch_pc holds, imem_addr holds.
//  Redirect
//   - Combinationally forces id_valid=0 and id_instr=NOP, so EX sees a bubble.
//   - Next edge: head=tail=0, count=0, fetch_pc <= redirect_pc, halted <= 0.
//   - No push or pop is performed in the redirect cycle.
//  Halt
//   - When a pushed imem_data[15:11]==5'b00000, the HALT word itself is enqueued and halted <= 1.
//   - While halted=1: push is suppressed and fetch_pc holds; the queue drains normally.
//   - A later redirect clears halted (HALT on a wrong path is squashed).
//  Stall with empty queue: no effect; pushes continue.
//  Outputs id_* are combinational from the head entry (registered storage), never from imem_data.
// STRUCTURE
//  - Shared package proc_pkg: NOP_INSTR=16'h0800, OP_HALT=5'b00000, PC_INC=16'd2, FQ_DEPTH.
//  - Sub-module fetch_queue_mem: DEPTH x (2*WIDTH) register array.
//    - One synchronous write port (we, waddr, wdata).
//    - One combinational read port (raddr, rdata).
//    - Storage has no reset; validity is tracked by count only.
//  - Top holds fetch_pc, head/tail pointers, count, halted, and the push/pop/redirect logic.
// TESTING
//  - Reset, then run with stall=0 and memory holding sequential words at 0,2,4.
//    -> id_valid rises cycle 2; id_pc_inc=2,4,6; count stays 1.
//  - stall=1 for 6 cycles from count=1.
//    -> count reaches 4 and holds; imem_addr frozen.
//    -> Release: 4 entries pop in order, no duplicate or lost PC.
//  - Queue full, stall=0.
//    -> push and pop in the same cycle; count stays 4; fetch_pc advances by 2 per cycle.
//  - redirect=1, redirect_pc=16'h0040 with count=3.
//    -> Same cycle: id_instr=16'h0800, id_valid=0.
//    -> Next: count=0, imem_addr=16'h0040.
//  - HALT word at addr 6.
//    -> halted=1 after its push; imem_addr holds 8; queue drains to 0.
//    -> A following redirect to 0 clears halted.
//  - rst asserted mid-run with redirect=1 and a full queue.
//    -> All state returns to reset values; redirect_pc is ignored.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants used by the fetch stage.
//   NOP_INSTR : word presented to decode when there is no valid instruction
//   OP_HALT   : opcode field (bits [15:11]) that stops instruction fetch
//   PC_INC    : byte increment between sequential instructions
//   FQ_DEPTH  : default prefetch queue depth
package proc_pkg;
   localparam logic [15:0] NOP_INSTR = 16'h0800;
   localparam logic [4:0]  OP_HALT   = 5'b00000;
   localparam logic [15:0] PC_INC    = 16'd2;
   localparam int          FQ_DEPTH  = 4;
endpackage

// File: rtl/fetch_queue_mem.sv
// Prefetch queue storage: DEPTH x DW register array.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write slot
//   wdata : write data
//   raddr : read slot
//   rdata : combinational read data
// Storage is intentionally unreset; the owner tracks validity with its count.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [DW-1:0]    wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [DW-1:0]    rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with prefetch FIFO between instruction memory and decode.
//   clk, rst           : clock, synchronous active-high reset
//   redirect/_pc       : EX branch/jump taken; flush queue and restart fetch at redirect_pc
//   stall              : decode does not consume the head entry this cycle
//   imem_addr/imem_data: same-cycle instruction memory read
//   id_instr/id_pc_inc : head entry {instr, pc+2}; NOP / 0 when id_valid=0
//   id_valid           : queue non-empty and no redirect this cycle
//   count              : occupancy 0..DEPTH
//   halted             : HALT word enqueued, fetching stopped until redirect
module fetch_queue
   import proc_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int PTR_W = 2,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             stall,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] id_instr,
   output logic [WIDTH-1:0] id_pc_inc,
   output logic             id_valid,
   output logic [PTR_W:0]   count,
   output logic             halted
);

   localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

   logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               halted_q, halted_d;
   logic               push, pop, is_halt;
   logic [WIDTH-1:0]   pc_next;
   logic [2*WIDTH-1:0] rdata;

   assign pc_next  = fetch_pc_q + WIDTH'(PC_INC);
   assign id_valid = (count_q != '0) & ~redirect;
   assign pop      = id_valid & ~stall;
   // A pop frees a slot in the same cycle, so a full queue still accepts a push.
   assign push     = ~redirect & ~halted_q & ((count_q != FULL) | pop);
   assign is_halt  = imem_data[WIDTH-1 -: 5] == OP_HALT;

   fetch_queue_mem #(
      .DEPTH(DEPTH),
      .PTR_W(PTR_W),
      .DW   (2*WIDTH)
   ) u_mem (
      .clk  (clk),
      .we   (push),
      .waddr(tail_q),
      .wdata({imem_data, pc_next}),
      .raddr(head_q),
      .rdata(rdata)
   );

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      halted_d   = halted_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         halted_d   = 1'b0;
      end else begin
         if (pop) head_d = head_q + 1'b1;
         if (push) begin
            tail_d     = tail_q + 1'b1;
            fetch_pc_d = pc_next;
            if (is_halt) halted_d = 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         halted_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign id_instr  = id_valid ? rdata[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
   assign id_pc_inc = id_valid ? rdata[WIDTH-1:0] : '0;
   assign count     = count_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst, redirect, stall;
   logic [15:0] redirect_pc, imem_addr, imem_data, id_instr, id_pc_inc;
   logic        id_valid, halted;
   logic [2:0]  count;
   logic        halt_en;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk        (clk),
      .rst        (rst),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .stall      (stall),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .id_instr   (id_instr),
      .id_pc_inc  (id_pc_inc),
      .id_valid   (id_valid),
      .count      (count),
      .halted     (halted)
   );

   function automatic logic [15:0] word(input logic [15:0] a);
      return 16'hA000 ^ a;
   endfunction

   always_comb imem_data = (halt_en && imem_addr == 16'd6) ? 16'h0000 : word(imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; redirect = 0; redirect_pc = 0; stall = 0; halt_en = 0;
      step(); step();
      checks++;
      if (count !== 3'd0 || id_valid !== 1'b0 || id_instr !== 16'h0800 || id_pc_inc !== 16'h0
          || imem_addr !== 16'h0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset: count=%0d valid=%b instr=%h pcinc=%h addr=%h halted=%b, want 0 0 0800 0000 0000 0",
                  count, id_valid, id_instr, id_pc_inc, imem_addr, halted);
      end
      rst = 0;
      #1;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 3; i++) begin
         logic [15:0] pc;
         pc = 16'(2 * i);
         step();
         checks++;
         if (id_valid !== 1'b1 || id_pc_inc !== pc + 16'd2 || id_instr !== word(pc) || count !== 3'd1) begin
            errors++;
            $display("FAIL stream[%0d]: valid=%b pcinc=%h instr=%h count=%0d, want 1 %h %h 1",
                     i, id_valid, id_pc_inc, id_instr, count, pc + 16'd2, word(pc));
         end
      end
   endtask

   task automatic test_stall_fill();
      // head pc_inc=6, fetch_pc=6; three pushes fill the queue then it holds
      stall = 1;
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (count !== 3'd4 || imem_addr !== 16'd12 || id_pc_inc !== 16'd6) begin
         errors++;
         $display("FAIL stall_fill: count=%0d addr=%h pcinc=%h, want 4 000c 0006", count, imem_addr, id_pc_inc);
      end
   endtask

   task automatic test_full_flow();
      stall = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (id_pc_inc !== 16'(8 + 2 * i) || id_instr !== word(16'(6 + 2 * i)) || count !== 3'd4
             || imem_addr !== 16'(14 + 2 * i)) begin
            errors++;
            $display("FAIL full_flow[%0d]: pcinc=%h instr=%h count=%0d addr=%h, want %h %h 4 %h",
                     i, id_pc_inc, id_instr, count, imem_addr, 16'(8 + 2 * i), word(16'(6 + 2 * i)),
                     16'(14 + 2 * i));
         end
      end
   endtask

   task automatic test_redirect();
      redirect = 1; redirect_pc = 16'h0020;
      step();
      redirect = 0; stall = 1;
      step(); step(); step();
      checks++;
      if (count !== 3'd3 || id_pc_inc !== 16'h0022 || id_instr !== word(16'h0020) || imem_addr !== 16'h0026) begin
         errors++;
         $display("FAIL redirect_fill: count=%0d pcinc=%h instr=%h addr=%h, want 3 0022 %h 0026",
                  count, id_pc_inc, id_instr, imem_addr, word(16'h0020));
      end
      redirect = 1; redirect_pc = 16'h0040;
      #1;
      checks++;
      if (id_instr !== 16'h0800 || id_valid !== 1'b0 || id_pc_inc !== 16'h0) begin
         errors++;
         $display("FAIL redirect_bubble: instr=%h valid=%b pcinc=%h, want 0800 0 0000", id_instr, id_valid, id_pc_inc);
      end
      step();
      redirect = 0; stall = 0;
      #1;
      checks++;
      if (count !== 3'd0 || imem_addr !== 16'h0040 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_next: count=%0d addr=%h valid=%b, want 0 0040 0", count, imem_addr, id_valid);
      end
   endtask

   task automatic test_halt();
      halt_en = 1; redirect = 1; redirect_pc = 16'h0000;
      step();
      redirect = 0;
      step(); step(); step(); step();
      checks++;
      if (halted !== 1'b1 || imem_addr !== 16'd8 || count !== 3'd1 || id_instr !== 16'h0000 || id_pc_inc !== 16'd8) begin
         errors++;
         $display("FAIL halt_push: halted=%b addr=%h count=%0d instr=%h pcinc=%h, want 1 0008 1 0000 0008",
                  halted, imem_addr, count, id_instr, id_pc_inc);
      end
      step(); step();
      checks++;
      if (halted !== 1'b1 || imem_addr !== 16'd8 || count !== 3'd0 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_drain: halted=%b addr=%h count=%0d valid=%b, want 1 0008 0 0",
                  halted, imem_addr, count, id_valid);
      end
      redirect = 1; redirect_pc = 16'h0000;
      step();
      redirect = 0; halt_en = 0;
      #1;
      checks++;
      if (halted !== 1'b0 || imem_addr !== 16'h0 || count !== 3'd0) begin
         errors++;
         $display("FAIL halt_clear: halted=%b addr=%h count=%0d, want 0 0000 0", halted, imem_addr, count);
      end
   endtask

   task automatic test_wrap();
      redirect = 1; redirect_pc = 16'hFFFE;
      step();
      redirect = 0;
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc_inc !== 16'h0000 || imem_addr !== 16'h0000 || id_instr !== word(16'hFFFE)) begin
         errors++;
         $display("FAIL pc_wrap: valid=%b pcinc=%h addr=%h instr=%h, want 1 0000 0000 %h",
                  id_valid, id_pc_inc, imem_addr, id_instr, word(16'hFFFE));
      end
   endtask

   task automatic test_reset_mid_run();
      redirect = 1; redirect_pc = 16'h0000;
      step();
      redirect = 0; stall = 1;
      step(); step(); step(); step();
      checks++;
      if (count !== 3'd4 || imem_addr !== 16'd8) begin
         errors++;
         $display("FAIL mid_fill: count=%0d addr=%h, want 4 0008", count, imem_addr);
      end
      rst = 1; redirect = 1; redirect_pc = 16'h1234;
      step();
      checks++;
      if (count !== 3'd0 || imem_addr !== 16'h0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: count=%0d addr=%h halted=%b, want 0 0000 0", count, imem_addr, halted);
      end
      rst = 0; redirect = 0; stall = 0;
      #1;
      checks++;
      if (id_valid !== 1'b0 || id_instr !== 16'h0800) begin
         errors++;
         $display("FAIL mid_reset_out: valid=%b instr=%h, want 0 0800", id_valid, id_instr);
      end
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc_inc !== 16'd2 || count !== 3'd1 || id_instr !== word(16'h0)) begin
         errors++;
         $display("FAIL mid_restart: valid=%b pcinc=%h count=%0d instr=%h, want 1 0002 1 %h",
                  id_valid, id_pc_inc, count, id_instr, word(16'h0));
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_fill();
      test_full_flow();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
